dma_mem_port: RTL and testbench
===============================

DMA_MEM_PORT -- requirements
Module: dma_mem_port

Interface
REQ-001 SHALL provide parameter ADDR_W, default 4, meaning byte-address width; internal RAM depth is 2^ADDR_W bytes.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-004 SHALL have port mode, input, 1, transfer direction: 1 = DMA writes into memory, 0 = memory sources data to DMA.
REQ-005 SHALL have port start, input, 1, one-cycle request to begin a transfer.
REQ-006 SHALL have port base_addr, input, ADDR_W, first byte address of the transfer.
REQ-007 SHALL have port length, input, ADDR_W+1, number of bytes to transfer, range 0..2^ADDR_W.
REQ-008 SHALL have port wr_valid, input, 1, DMA-to-memory nibble valid.
REQ-009 SHALL have port wr_data, input, 4, DMA-to-memory nibble.
REQ-010 SHALL have port wr_ready, output, 1, memory ready to accept a nibble.
REQ-011 SHALL have port rd_valid, output, 1, memory-to-DMA nibble valid.
REQ-012 SHALL have port rd_data, output, 4, memory-to-DMA nibble.
REQ-013 SHALL have port rd_ready, input, 1, DMA ready to accept a nibble.
REQ-014 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port done, output, 1, one-cycle pulse marking transfer completion.
REQ-016 SHALL have port byte_count, output, ADDR_W+1, bytes completed in the current or most recent transfer.

Function
REQ-017 A nibble SHALL transfer only on a rising edge where valid and ready are both high; no other condition moves data.
REQ-018 States SHALL be IDLE, WR, RD_LOAD, RD_SEND, FIN.
REQ-019 In IDLE, start=1 SHALL latch mode, base_addr into addr, length into len, clear byte_count and nibble phase, and go to WR (mode=1) or RD_LOAD (mode=0); if length=0 it SHALL go to FIN instead.
REQ-020 start SHALL be ignored in every state except IDLE; mode, base_addr, length SHALL be sampled only at accepted start.
REQ-021 wr_ready SHALL be 1 exactly while in WR; rd_valid SHALL be 1 exactly while in RD_SEND.
REQ-022 Nibble order SHALL be low nibble first, then high nibble, in both directions.
REQ-023 In WR, the first accepted nibble SHALL be held in an internal register; the second SHALL complete the byte {high,low}, written to ram[addr] on that same edge.
REQ-024 On each completed byte, addr SHALL increment modulo 2^ADDR_W (wraps from all-ones to 0) and byte_count SHALL increment by 1.
REQ-025 When byte_count reaches len after an increment, state SHALL go to FIN on that edge.
REQ-026 RD_LOAD SHALL last one cycle, copying ram[addr] into a byte register, then go to RD_SEND with phase=low.
REQ-027 In RD_SEND, rd_data SHALL be byte_reg[3:0] when phase=low and byte_reg[7:4] when phase=high, stable while rd_valid=1 and rd_ready=0.
REQ-028 A low-nibble accept SHALL set phase=high and stay in RD_SEND; a high-nibble accept SHALL increment addr and byte_count, then go to FIN if byte_count reaches len, else RD_LOAD.
REQ-029 Per byte, read throughput SHALL be 3 cycles minimum (RD_LOAD plus two accepts); write throughput SHALL be 2 cycles minimum.
REQ-030 FIN SHALL last one cycle with done=1, then return to IDLE; done SHALL be 0 in all other states.
REQ-031 rd_data SHALL be 0 outside RD_SEND.
REQ-032 start coinciding with FIN SHALL be ignored; the next start SHALL be accepted in IDLE.
REQ-033 byte_count SHALL hold its final value in IDLE until the next accepted start.

Reset
REQ-034 resetn=0 at a rising edge SHALL force state=IDLE, addr=0, len=0, byte_count=0, phase=low, holding nibble=0, byte_reg=0; outputs wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0.
REQ-035 RAM contents SHALL NOT be reset; bytes written before a mid-transfer reset SHALL persist, a pending low nibble SHALL be discarded, and no done pulse SHALL be produced.

Verification
REQ-036 Write: mode=1, base_addr=2, length=2, nibbles 5,A,3,C with wr_valid held -> ram[2]=A5, ram[3]=C3, done pulse 1 cycle after final accept, byte_count=2.
REQ-037 Read back: mode=0, base_addr=2, length=2, rd_ready=1 -> rd_data sequence 5,A,3,C, each byte preceded by one RD_LOAD cycle with rd_valid=0, done then IDLE.
REQ-038 Wrap: ADDR_W=4, base_addr=15, length=2 write of bytes 11,22 -> ram[15]=11, ram[0]=22.
REQ-039 Backpressure: read with rd_ready toggling 1,0,0,1 -> rd_data holds unchanged during stalled cycles, no nibble duplicated or lost.
REQ-040 Edge cases: length=0 -> FIN next cycle, done=1, byte_count=0; start while busy ignored; reset after one nibble of a write -> IDLE, all outputs 0, target byte unchanged.

Source files
------------

// File: rtl/dma_mem_port.sv
// Nibble-serial DMA port onto a small byte-wide RAM.
// Writes assemble {high,low} nibbles into a byte; reads stream each byte low nibble first.
module dma_mem_port #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mode,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              wr_valid,
  input  logic [3:0]        wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [3:0]        rd_data,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_LOAD = 3'd2,
    RD_SEND = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic              r_phase;
  logic [3:0]        r_nib;
  logic [7:0]        r_byte;
  logic [7:0]        r_ram [2**ADDR_W];

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic              w_last;

  assign w_wr_acc  = (r_state == WR) && wr_valid;
  assign w_rd_acc  = (r_state == RD_SEND) && rd_ready;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_last    = (w_cnt_nxt == r_len);

  // Outputs decode directly from the state register, so they change only at clock edges.
  assign wr_ready   = (r_state == WR);
  assign rd_valid   = (r_state == RD_SEND);
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == FIN);
  assign byte_count = r_cnt;
  assign rd_data    = (r_state != RD_SEND) ? 4'h0 : (r_phase ? r_byte[7:4] : r_byte[3:0]);

  // RAM has no reset; a write coinciding with reset is dropped along with the transfer.
  always_ff @(posedge clk) begin
    if (resetn && w_wr_acc && r_phase)
      r_ram[r_addr] <= {wr_data, r_nib};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_nib   <= 4'h0;
      r_byte  <= 8'h00;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr  <= base_addr;
            r_len   <= length;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            if (length == '0) r_state <= FIN;
            else if (mode)    r_state <= WR;
            else              r_state <= RD_LOAD;
          end
        end
        WR: begin
          if (w_wr_acc) begin
            if (!r_phase) begin
              r_nib   <= wr_data;
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_addr  <= r_addr + 1'b1;
              r_cnt   <= w_cnt_nxt;
              if (w_last) r_state <= FIN;
            end
          end
        end
        RD_LOAD: begin
          r_byte  <= r_ram[r_addr];
          r_phase <= 1'b0;
          r_state <= RD_SEND;
        end
        RD_SEND: begin
          if (w_rd_acc) begin
            if (!r_phase) begin
              r_phase <= 1'b1;
            end else begin
              r_phase <= 1'b0;
              r_addr  <= r_addr + 1'b1;
              r_cnt   <= w_cnt_nxt;
              r_state <= w_last ? FIN : RD_LOAD;
            end
          end
        end
        FIN:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_mem_port.sv
// Bench for dma_mem_port: directed and randomized transfers checked against a byte-array memory model.
module tb_dma_mem_port;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          resetn, mode, start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          wr_valid;
  logic [3:0]    wr_data;
  logic          wr_ready, rd_valid;
  logic [3:0]    rd_data;
  logic          rd_ready, busy, done;
  logic [AW:0]   byte_count;

  logic [7:0] ref_ram [DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  dma_mem_port #(.ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .mode(mode), .start(start),
    .base_addr(base_addr), .length(length),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .done(done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_write(input int base, input logic [7:0] bytes[$]);
    logic [3:0] nq[$];
    int len, idx, cyc;
    len = bytes.size();
    for (int i = 0; i < len; i++) begin
      ref_ram[(base + i) % DEPTH] = bytes[i];
      nq.push_back(bytes[i][3:0]);
      nq.push_back(bytes[i][7:4]);
    end
    mode = 1'b1; base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("wr_busy", busy, 1);
    idx = 0; cyc = 0;
    while (idx < 2 * len && cyc < 300) begin
      chk("wr_ready", wr_ready, 1);
      chk("wr_done_early", done, 0);
      wr_valid = ($urandom % 3) != 0;
      wr_data  = nq[idx];
      if ($urandom % 6 == 0) begin
        start = 1'b1; mode = 1'b0; length = 1; base_addr = AW'($urandom);
      end
      @(negedge clk);
      start = 1'b0; mode = 1'b1;
      if (wr_valid) idx++;
      cyc++;
    end
    wr_valid = 1'b0;
    chk("wr_timeout", cyc < 300, 1);
    chk("wr_fin_done", done, 1);
    chk("wr_fin_count", byte_count, len);
    chk("wr_fin_ready", wr_ready, 0);
    start = 1'b1; mode = 1'b0; length = 3;
    @(negedge clk);
    start = 1'b0;
    chk("wr_idle_done", done, 0);
    chk("wr_idle_busy", busy, 0);
    chk("wr_idle_count", byte_count, len);
  endtask

  // rdy_mode: 0 = always ready, 1 = repeating 1,0,0,1, 2 = random.
  task automatic do_read(input int base, input int len, input int rdy_mode);
    logic [3:0] nq[$];
    logic [3:0] pat [4];
    bit load, r;
    int idx, cyc;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    for (int i = 0; i < len; i++) begin
      nq.push_back(ref_ram[(base + i) % DEPTH][3:0]);
      nq.push_back(ref_ram[(base + i) % DEPTH][7:4]);
    end
    mode = 1'b0; base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    load = 1'b1; idx = 0; cyc = 0;
    while (idx < 2 * len && cyc < 300) begin
      chk("rd_done_early", done, 0);
      r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? pat[cyc % 4][0] : 1'($urandom);
      rd_ready = r;
      if ($urandom % 6 == 0) begin
        start = 1'b1; mode = 1'b1; length = 2;
      end
      if (load) begin
        chk("rd_load_valid", rd_valid, 0);
        chk("rd_load_data", rd_data, 0);
        load = 1'b0;
        @(negedge clk);
      end else begin
        chk("rd_valid", rd_valid, 1);
        chk("rd_data", rd_data, nq[idx]);
        @(negedge clk);
        if (r) begin
          idx++;
          if (idx % 2 == 0 && idx < 2 * len) load = 1'b1;
        end
      end
      start = 1'b0; mode = 1'b0;
      cyc++;
    end
    rd_ready = 1'b0;
    chk("rd_timeout", cyc < 300, 1);
    chk("rd_fin_done", done, 1);
    chk("rd_fin_count", byte_count, len);
    chk("rd_fin_valid", rd_valid, 0);
    @(negedge clk);
    chk("rd_idle_done", done, 0);
    chk("rd_idle_busy", busy, 0);
    chk("rd_idle_count", byte_count, len);
  endtask

  initial begin
    logic [7:0] q[$];
    int b, l;
    resetn = 1'b0; mode = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    wr_valid = 1'b0; wr_data = 4'h0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("rst");
    chk("rst_count", byte_count, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Fill the whole RAM so every later read has a known value.
    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(8'($urandom));
    do_write(0, q);

    q = {8'hA5, 8'hC3};
    do_write(2, q);
    do_read(2, 2, 0);

    q = {8'h11, 8'h22};
    do_write(15, q);
    do_read(15, 2, 0);
    chk("wrap_ram15", ref_ram[15], 8'h11);
    chk("wrap_ram0", ref_ram[0], 8'h22);

    do_read(0, 4, 1);

    q = {};
    do_write(5, q);
    do_read(9, 0, 0);

    // Reset after one nibble of a write: the target byte must survive.
    mode = 1'b1; base_addr = 4'd7; length = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; wr_valid = 1'b1; wr_data = ~ref_ram[7][3:0];
    @(negedge clk);
    wr_valid = 1'b0; resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk_quiet("midrst");
    chk("midrst_count", byte_count, 0);
    @(negedge clk);
    chk("midrst_done", done, 0);
    do_read(7, 1, 0);

    for (int it = 0; it < 20; it++) begin
      b = $urandom % DEPTH;
      l = $urandom_range(0, DEPTH);
      if ($urandom % 2 == 0) begin
        q = {};
        for (int i = 0; i < l; i++) q.push_back(8'($urandom));
        do_write(b, q);
      end else begin
        do_read(b, l, 2);
      end
    end
    do_read(3, DEPTH, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
